a23_cache_flush_seq: RTL and testbench
======================================

// Module: a23_cache_flush_seq
// PURPOSE
//  Downstream consumer of the CP15 flush/enable outputs. Turns a one-cycle cache-flush request
//  into a set-by-set invalidate walk of the cache tag RAMs and stalls the core until it finishes.
//  Also runs an init walk after reset, because tag RAM contents are undefined at power-up.
//  Sits between the co-processor and the a23_cache tag arrays.
// PARAMETERS
//  SETS        256  lines per way; power of 2, minimum 2
//  WAYS        4    cache ways; one tag write-enable per way
//  SET_W       8    log2(SETS); address width of the walk counter
// PORTS
//  i_clk           in   1      core clock
//  i_rst_n         in   1      asynchronous reset, active low
//  i_system_rdy    in   1      system ready; the walk does not start or advance while low
//  i_cache_flush   in   1      single-cycle flush request from CP15 (write to reg 1)
//  i_cache_enable  in   1      CP15 cache enable (cache_control bit 0)
//  i_cache_idle    in   1      high when the cache has no fill or write-back in flight
//  o_flush_stall   out  1      stall request into the core fetch-stall logic
//  o_tag_wenable   out  WAYS   per-way tag RAM write strobe
//  o_tag_addr      out  SET_W  set index being invalidated
//  o_tag_valid     out  1      valid bit written into the tag; always 0
//  o_lru_reset     out  1      one-cycle pulse that clears the replacement pointers at walk start
//  o_flush_done    out  1      one-cycle pulse after the last set is written
// BEHAVIOUR
//  Reset (async): state=INIT, set counter=0, pending=0; every output 0 except o_flush_stall=1.
//  States: INIT, IDLE, WAIT_IDLE, WALK, DONE.
//   INIT      -> WALK when i_system_rdy=1. No wait for idle, because the cache is not yet active.
//   IDLE      -> WAIT_IDLE on i_cache_flush=1.
//   WAIT_IDLE -> WALK on the first cycle with i_cache_idle=1 && i_system_rdy=1.
//   WALK      on each cycle with i_system_rdy=1:
//             o_tag_wenable={WAYS{1}}, o_tag_addr=counter, then counter+1.
//             At counter==SETS-1: counter wraps to 0, next state is DONE.
//             If i_system_rdy=0: hold the counter and drive wenable=0.
//   DONE      o_flush_done=1 for one cycle.
//             If pending=1: clear pending, go to WAIT_IDLE. Otherwise go to IDLE.
//  o_lru_reset pulses in the cycle of the transition into WALK.
//  o_flush_stall = (state!=IDLE) | i_cache_flush. The stall is combinational so no fetch slips
//   after the request. It is high from the request cycle through the DONE cycle inclusive.
//  Latency for one flush with the cache idle:
//   request at cycle N; writes at N+2 .. N+SETS+1; done at N+SETS+2.
//  A flush request in WAIT_IDLE is absorbed with no effect.
//   In WALK or DONE it sets pending, so exactly one extra full walk follows.
//   Multiple requests in one walk collapse to a single pending flag.
//  A flush request in INIT is ignored; the init walk already covers it.
//  Async reset mid-walk abandons the walk. The sequencer returns to INIT and re-walks from set 0.
//  o_tag_valid is tied 0. Tags are registered outputs, except o_flush_stall.
// CONFIGURATION
//  A23_FLUSH_ON_DISABLE_EN defined:
//   A 1->0 edge on i_cache_enable, detected with a registered copy, is treated exactly like
//   i_cache_flush, including the pending rules above.
//   The registered copy resets to 0.
//  Not defined: i_cache_enable is unused, and disabling the cache leaves tags untouched.
// STRUCTURE
//  Shared package a23_cache_pkg:
//   state encoding localparams (INIT/IDLE/WAIT_IDLE/WALK/DONE);
//   SETS/WAYS/SET_W defaults, shared with a23_cache.
//  Sub-module a23_flush_counter: SET_W-bit counter with enable, wrap flag and async clear.
//  The FSM, the pending flag and the output registers stay in the top module.
// TESTING
//  1 Release i_rst_n, set i_system_rdy=1 at cycle 5
//    -> o_lru_reset pulses once; 256 writes with o_tag_addr 0..255 and wenable=4'hF;
//       o_flush_done pulses once; stall falls the cycle after.
//  2 Idle, pulse i_cache_flush with i_cache_idle=1
//    -> stall in the same cycle; first write 2 cycles later at addr 0; done 258 cycles after request.
//  3 Flush with i_cache_idle=0 for 10 cycles -> no tag writes until idle rises; stall held throughout.
//  4 Flush pulses at walk addr 17 and addr 200
//    -> exactly one extra 256-set walk after the first done; two done pulses total.
//  5 Drop i_system_rdy for 3 cycles at addr 100
//    -> wenable=0 for 3 cycles; resume at addr 100; no set skipped or repeated.
//  6 Assert i_rst_n=0 at addr 50, then release -> outputs reset immediately; new INIT walk from 0.
//    With A23_FLUSH_ON_DISABLE_EN, drive i_cache_enable 1->0 -> full walk;
//    without the macro -> no writes.

Source files
------------

// File: rtl/a23_cache_pkg.sv
// Shared cache definitions: geometry defaults used by a23_cache and the flush
// sequencer, plus the flush sequencer state encoding.
package a23_cache_pkg;

  localparam int CACHE_SETS  = 256;
  localparam int CACHE_WAYS  = 4;
  localparam int CACHE_SET_W = 8;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd2;
  localparam logic [2:0] ST_WALK      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    S_INIT      = ST_INIT,
    S_IDLE      = ST_IDLE,
    S_WAIT_IDLE = ST_WAIT_IDLE,
    S_WALK      = ST_WALK,
    S_DONE      = ST_DONE
  } state_t;

endpackage

// File: rtl/a23_cache_flush_seq_if.sv
// Flush sequencer bus: CP15/system controls in, tag RAM invalidate strobes and
// core stall out. The master side drives the requests, the sequencer is the slave.
interface a23_cache_flush_seq_if
  import a23_cache_pkg::*;
#(
  parameter int WAYS  = CACHE_WAYS,
  parameter int SET_W = CACHE_SET_W
);
  logic             i_system_rdy;
  logic             i_cache_flush;
  logic             i_cache_enable;
  logic             i_cache_idle;
  logic             o_flush_stall;
  logic [WAYS-1:0]  o_tag_wenable;
  logic [SET_W-1:0] o_tag_addr;
  logic             o_tag_valid;
  logic             o_lru_reset;
  logic             o_flush_done;

  modport master (
    output i_system_rdy, i_cache_flush, i_cache_enable, i_cache_idle,
    input  o_flush_stall, o_tag_wenable, o_tag_addr, o_tag_valid,
           o_lru_reset, o_flush_done
  );

  modport slave (
    input  i_system_rdy, i_cache_flush, i_cache_enable, i_cache_idle,
    output o_flush_stall, o_tag_wenable, o_tag_addr, o_tag_valid,
           o_lru_reset, o_flush_done
  );
endinterface

// File: rtl/a23_flush_counter.sv
// Set index counter for the invalidate walk: advances on en, wraps to zero
// after LAST, and flags the last set so the FSM knows the walk is complete.
module a23_flush_counter #(
  parameter int SET_W = 8,
  parameter int LAST  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [SET_W-1:0] count,
  output logic             wrap
);
  localparam logic [SET_W-1:0] LAST_V = SET_W'(LAST);

  assign wrap = (count == LAST_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (en) count <= wrap ? '0 : count + SET_W'(1);
  end
endmodule

// File: rtl/a23_cache_flush_seq.sv
// Cache flush sequencer: walks every tag set to invalidate it after reset and on
// each CP15 flush request. Optional A23_FLUSH_ON_DISABLE_EN also flushes on cache disable.
module a23_cache_flush_seq
  import a23_cache_pkg::*;
#(
  parameter int SETS  = CACHE_SETS,
  parameter int WAYS  = CACHE_WAYS,
  parameter int SET_W = CACHE_SET_W
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  a23_cache_flush_seq_if.slave bus
);
  state_t           state, state_nx;
  logic             pending, pending_nx;
  logic             issue, lru_nx, done_nx;
  logic             last_q, flush_req, wrap;
  logic [SET_W-1:0] count;
  logic [WAYS-1:0]  wen_q;
  logic [SET_W-1:0] addr_q;
  logic             lru_q, done_q;

`ifdef A23_FLUSH_ON_DISABLE_EN
  logic enable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) enable_q <= 1'b0;
    else          enable_q <= bus.i_cache_enable;
  end

  assign flush_req = bus.i_cache_flush | (enable_q & ~bus.i_cache_enable);
`else
  logic unused_enable;
  assign unused_enable = bus.i_cache_enable;
  assign flush_req     = bus.i_cache_flush;
`endif

  a23_flush_counter #(.SET_W(SET_W), .LAST(SETS - 1)) u_counter (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (issue),
    .count (count),
    .wrap  (wrap)
  );

  // issue = a set write is launched this cycle and appears on the tag outputs next cycle
  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    issue      = 1'b0;
    lru_nx     = 1'b0;
    done_nx    = 1'b0;
    case (state)
      S_INIT: begin
        if (bus.i_system_rdy) begin
          issue    = 1'b1;
          lru_nx   = 1'b1;
          state_nx = S_WALK;
        end
      end
      S_IDLE: begin
        if (flush_req) state_nx = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (bus.i_cache_idle && bus.i_system_rdy) begin
          issue    = 1'b1;
          lru_nx   = 1'b1;
          state_nx = S_WALK;
        end
      end
      S_WALK: begin
        if (flush_req) pending_nx = 1'b1;
        if (last_q) begin
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end else if (bus.i_system_rdy) begin
          issue = 1'b1;
        end
      end
      S_DONE: begin
        pending_nx = 1'b0;
        state_nx   = (pending || flush_req) ? S_WAIT_IDLE : S_IDLE;
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_INIT;
      pending <= 1'b0;
      last_q  <= 1'b0;
      wen_q   <= '0;
      addr_q  <= '0;
      lru_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      last_q  <= issue & wrap;
      wen_q   <= issue ? '1 : '0;
      lru_q   <= lru_nx;
      done_q  <= done_nx;
      if (issue) addr_q <= count;
    end
  end

  // Stall is combinational so the fetch right after the request is already held
  assign bus.o_flush_stall = (state != S_IDLE) | flush_req;
  assign bus.o_tag_wenable = wen_q;
  assign bus.o_tag_addr    = addr_q;
  assign bus.o_tag_valid   = 1'b0;
  assign bus.o_lru_reset   = lru_q;
  assign bus.o_flush_done  = done_q;
endmodule

// File: tb/tb_a23_cache_flush_seq.sv
// Directed bench for a23_cache_flush_seq: expected LRU/write/done events are queued
// with their cycle stamps by the stimulus and consumed by a negedge monitor.
module tb_a23_cache_flush_seq;
  import a23_cache_pkg::*;

  localparam int EV_LRU  = 1;
  localparam int EV_WR   = 2;
  localparam int EV_DONE = 3;
  localparam int ALL_WEN = (1 << CACHE_WAYS) - 1;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  sb[$];

  a23_cache_flush_seq_if #(.WAYS(CACHE_WAYS), .SET_W(CACHE_SET_W)) bus ();

  a23_cache_flush_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Full walk whose first write is visible at cycle s; optional stall of gap_len cycles before gap_at
  task automatic expect_walk(input int s, input int gap_at, input int gap_len);
    sb.push_back('{EV_LRU, 0, s});
    for (int a = 0; a < CACHE_SETS; a++)
      sb.push_back('{EV_WR, (ALL_WEN << CACHE_SET_W) | a, s + a + ((a >= gap_at) ? gap_len : 0)});
    sb.push_back('{EV_DONE, 0, s + CACHE_SETS + gap_len});
  endtask

  task automatic observe(input int kind, input int data);
    ev_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_event", kind, 0);
    end else begin
      e = sb.pop_front();
      check("sb_event", (kind << 16) | data, (e.kind << 16) | e.data);
      check("sb_event_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_lru_reset) observe(EV_LRU, 0);
    if (bus.o_tag_wenable != '0) begin
      observe(EV_WR, (int'(bus.o_tag_wenable) << CACHE_SET_W) | int'(bus.o_tag_addr));
      check("tag_valid", int'(bus.o_tag_valid), 0);
    end
    if (bus.o_flush_done) observe(EV_DONE, 0);
  end

  initial begin
    int c, s, r;
    bus.i_system_rdy   = 1'b0;
    bus.i_cache_flush  = 1'b0;
    bus.i_cache_enable = 1'b1;
    bus.i_cache_idle   = 1'b1;
    #1;
    check("rst_stall", int'(bus.o_flush_stall), 1);
    check("rst_wen", int'(bus.o_tag_wenable), 0);
    check("rst_addr", int'(bus.o_tag_addr), 0);
    check("rst_lru", int'(bus.o_lru_reset), 0);
    check("rst_done", int'(bus.o_flush_done), 0);
    check("rst_valid", int'(bus.o_tag_valid), 0);

    // 1: init walk once the system is ready; a flush while in INIT is ignored
    run_to(2);
    rst_n = 1'b1;
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(5);
    check("t1_init_stall", int'(bus.o_flush_stall), 1);
    s = cyc + 1;
    expect_walk(s, CACHE_SETS, 0);
    bus.i_system_rdy = 1'b1;
    run_to(s + 256);
    check("t1_stall_done", int'(bus.o_flush_stall), 1);
    run_to(s + 257);
    check("t1_stall_fall", int'(bus.o_flush_stall), 0);

    // 2: single flush with the cache idle
    run_to(cyc + 3);
    c = cyc;
    check("t2_stall_before", int'(bus.o_flush_stall), 0);
    expect_walk(c + 2, CACHE_SETS, 0);
    bus.i_cache_flush = 1'b1;
    #1;
    check("t2_stall_same_cycle", int'(bus.o_flush_stall), 1);
    tick();
    bus.i_cache_flush = 1'b0;
    #1;
    check("t2_stall_wait", int'(bus.o_flush_stall), 1);
    run_to(c + 258);
    check("t2_stall_done", int'(bus.o_flush_stall), 1);
    run_to(c + 259);
    check("t2_stall_fall", int'(bus.o_flush_stall), 0);

    // 3: cache busy for 10 cycles after the request
    run_to(cyc + 2);
    bus.i_cache_idle = 1'b0;
    c = cyc;
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    for (int k = 1; k < 10; k++) begin
      check("t3_stall_busy", int'(bus.o_flush_stall), 1);
      tick();
    end
    expect_walk(c + 11, CACHE_SETS, 0);
    bus.i_cache_idle = 1'b1;
    run_to(c + 11 + 257);
    check("t3_stall_fall", int'(bus.o_flush_stall), 0);

    // 4: two requests during a walk collapse into one extra walk
    run_to(cyc + 2);
    c = cyc;
    s = c + 2;
    expect_walk(s, CACHE_SETS, 0);
    expect_walk(s + 258, CACHE_SETS, 0);
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(s + 17);
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(s + 200);
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(s + 257);
    check("t4_stall_between", int'(bus.o_flush_stall), 1);
    run_to(s + 258 + 257);
    check("t4_stall_fall", int'(bus.o_flush_stall), 0);
    run_to(cyc + 20);
    check("t4_no_third_walk", int'(bus.o_flush_stall), 0);

    // 5: system not ready for 3 cycles around set 100
    c = cyc;
    s = c + 2;
    expect_walk(s, 100, 3);
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(s + 99);
    bus.i_system_rdy = 1'b0;
    run_to(s + 102);
    check("t5_stall_hold", int'(bus.o_flush_stall), 1);
    bus.i_system_rdy = 1'b1;
    run_to(s + 260);
    check("t5_stall_fall", int'(bus.o_flush_stall), 0);

    // 6: asynchronous reset at set 50 restarts with an init walk
    run_to(cyc + 2);
    c = cyc;
    s = c + 2;
    expect_walk(s, CACHE_SETS, 0);
    bus.i_cache_flush = 1'b1;
    tick();
    bus.i_cache_flush = 1'b0;
    run_to(s + 50);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wen", int'(bus.o_tag_wenable), 0);
    check("t6_rst_addr", int'(bus.o_tag_addr), 0);
    check("t6_rst_stall", int'(bus.o_flush_stall), 1);
    check("t6_rst_done", int'(bus.o_flush_done), 0);
    check("t6_sets_before_reset", sb.size(), CACHE_SETS - 50 + 1);
    sb.delete();
    tick();
    tick();
    r = cyc;
    expect_walk(r + 1, CACHE_SETS, 0);
    rst_n = 1'b1;
    run_to(r + 1 + 257);
    check("t6_stall_fall", int'(bus.o_flush_stall), 0);

    // 7: cache disable edge
    run_to(cyc + 2);
    c = cyc;
`ifdef A23_FLUSH_ON_DISABLE_EN
    expect_walk(c + 2, CACHE_SETS, 0);
    bus.i_cache_enable = 1'b0;
    #1;
    check("t7_disable_stall", int'(bus.o_flush_stall), 1);
    run_to(c + 259);
    check("t7_stall_fall", int'(bus.o_flush_stall), 0);
`else
    bus.i_cache_enable = 1'b0;
    #1;
    check("t7_disable_stall", int'(bus.o_flush_stall), 0);
    run_to(c + 40);
    check("t7_disable_idle", int'(bus.o_flush_stall), 0);
`endif

    run_to(cyc + 5);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
